// File: rtl/rdata_router.sv
// ---------------------------------------------------------------------------
// rdata_router
//   Routes AXI read-data bursts from three slaves to three masters. An idle
//   router grants one valid slave. The master index comes from bits [7:4] of
//   that slave's RID. The burst then stays locked until a handshake with
//   RLAST=1. Beats addressed to a master index above 2 are accepted and
//   discarded, and DROP flags each one.
//
//   Configuration macro: RDATA_ROUTER_RR_EN
//     undefined : fixed priority S0 > S1 > S2
//     defined   : round-robin, priority starts after the last granted slave
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     RID/RDATA/RRESP/RLAST/RVALID_Si  slave-side read data (inputs)
//     RREADY_Si                     ready back to slave i
//     RID/RDATA/RRESP/RLAST/RVALID_Mj  master-side read data (outputs)
//     RREADY_Mj                     ready from master j
//     BUSY                          high while a burst is locked
//     DROP                          one pulse per beat sunk to an invalid index
// ---------------------------------------------------------------------------
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module rdata_router (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [`AXI_IDS_BITS-1:0]   RID_S0,
   input  logic [`AXI_DATA_BITS-1:0]  RDATA_S0,
   input  logic [1:0]                 RRESP_S0,
   input  logic                       RLAST_S0,
   input  logic                       RVALID_S0,
   output logic                       RREADY_S0,
   input  logic [`AXI_IDS_BITS-1:0]   RID_S1,
   input  logic [`AXI_DATA_BITS-1:0]  RDATA_S1,
   input  logic [1:0]                 RRESP_S1,
   input  logic                       RLAST_S1,
   input  logic                       RVALID_S1,
   output logic                       RREADY_S1,
   input  logic [`AXI_IDS_BITS-1:0]   RID_S2,
   input  logic [`AXI_DATA_BITS-1:0]  RDATA_S2,
   input  logic [1:0]                 RRESP_S2,
   input  logic                       RLAST_S2,
   input  logic                       RVALID_S2,
   output logic                       RREADY_S2,
   output logic [`AXI_ID_BITS-1:0]    RID_M0,
   output logic [`AXI_DATA_BITS-1:0]  RDATA_M0,
   output logic [1:0]                 RRESP_M0,
   output logic                       RLAST_M0,
   output logic                       RVALID_M0,
   input  logic                       RREADY_M0,
   output logic [`AXI_ID_BITS-1:0]    RID_M1,
   output logic [`AXI_DATA_BITS-1:0]  RDATA_M1,
   output logic [1:0]                 RRESP_M1,
   output logic                       RLAST_M1,
   output logic                       RVALID_M1,
   input  logic                       RREADY_M1,
   output logic [`AXI_ID_BITS-1:0]    RID_M2,
   output logic [`AXI_DATA_BITS-1:0]  RDATA_M2,
   output logic [1:0]                 RRESP_M2,
   output logic                       RLAST_M2,
   output logic                       RVALID_M2,
   input  logic                       RREADY_M2,
   output logic                       BUSY,
   output logic                       DROP
);

   typedef enum logic {IDLE, LOCK} state_e;

   state_e      state_q, state_d;
   logic [1:0]  gnt_slv_q, gnt_slv_d;
   logic [3:0]  gnt_mst_q, gnt_mst_d;
`ifdef RDATA_ROUTER_RR_EN
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic        found;
   logic [1:0]  rr_idx;
`endif

   logic [2:0]                 rvalid_s;
   logic [2:0]                 rready_m;
   logic [2:0]                 rready_s;
   logic [1:0]                 pick;
   logic [`AXI_IDS_BITS-1:0]   pick_rid;

   logic [`AXI_IDS_BITS-1:0]   sel_rid;
   logic [`AXI_DATA_BITS-1:0]  sel_data;
   logic [1:0]                 sel_resp;
   logic                       sel_last;
   logic                       sel_valid;
   logic                       sel_ready;
   logic                       hs;
   logic                       drop;

   logic [`AXI_ID_BITS-1:0]    rid_m   [3];
   logic [`AXI_DATA_BITS-1:0]  rdata_m [3];
   logic [1:0]                 rresp_m [3];
   logic                       rlast_m [3];
   logic                       rvalid_m[3];

   assign rvalid_s = {RVALID_S2, RVALID_S1, RVALID_S0};
   assign rready_m = {RREADY_M2, RREADY_M1, RREADY_M0};

   // Arbitration: choose one slave among those currently valid.
   always_comb begin
`ifdef RDATA_ROUTER_RR_EN
      pick   = '0;
      found  = 1'b0;
      rr_idx = '0;
      // Scan the slaves in order, starting with the one after the last grant.
      for (int unsigned k = 1; k <= 3; k++) begin
         rr_idx = 2'((32'(rr_ptr_q) + k) % 32'd3);
         if (!found && rvalid_s[rr_idx]) begin
            pick  = rr_idx;
            found = 1'b1;
         end
      end
`else
      if (rvalid_s[0])      pick = 2'd0;
      else if (rvalid_s[1]) pick = 2'd1;
      else                  pick = 2'd2;
`endif
   end

   always_comb begin
      case (pick)
         2'd0:    pick_rid = RID_S0;
         2'd1:    pick_rid = RID_S1;
         2'd2:    pick_rid = RID_S2;
         default: pick_rid = '0;
      endcase
   end

   // Select the granted slave's signals.
   always_comb begin
      sel_rid   = '0;
      sel_data  = '0;
      sel_resp  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      case (gnt_slv_q)
         2'd0: begin
            sel_rid = RID_S0; sel_data = RDATA_S0; sel_resp = RRESP_S0;
            sel_last = RLAST_S0; sel_valid = RVALID_S0;
         end
         2'd1: begin
            sel_rid = RID_S1; sel_data = RDATA_S1; sel_resp = RRESP_S1;
            sel_last = RLAST_S1; sel_valid = RVALID_S1;
         end
         2'd2: begin
            sel_rid = RID_S2; sel_data = RDATA_S2; sel_resp = RRESP_S2;
            sel_last = RLAST_S2; sel_valid = RVALID_S2;
         end
         default: ;
      endcase
   end

   // Next state, grant registers and all routed outputs.
   always_comb begin
      state_d   = state_q;
      gnt_slv_d = gnt_slv_q;
      gnt_mst_d = gnt_mst_q;
`ifdef RDATA_ROUTER_RR_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      rready_s  = '0;
      sel_ready = 1'b0;
      hs        = 1'b0;
      drop      = 1'b0;
      for (int unsigned j = 0; j < 3; j++) begin
         rid_m[j]    = '0;
         rdata_m[j]  = '0;
         rresp_m[j]  = '0;
         rlast_m[j]  = 1'b0;
         rvalid_m[j] = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (|rvalid_s) begin
               state_d   = LOCK;
               gnt_slv_d = pick;
               gnt_mst_d = pick_rid[7:4];
`ifdef RDATA_ROUTER_RR_EN
               rr_ptr_d  = pick;
`endif
            end
         end
         LOCK: begin
            if (gnt_mst_q < 4'd3) begin
               for (int unsigned j = 0; j < 3; j++) begin
                  if (gnt_mst_q == 4'(j)) begin
                     rvalid_m[j] = sel_valid;
                     rid_m[j]    = sel_rid[3:0];
                     rdata_m[j]  = sel_data;
                     rresp_m[j]  = sel_resp;
                     rlast_m[j]  = sel_last;
                     sel_ready   = rready_m[j];
                  end
               end
               hs = sel_valid && sel_ready;
            end else begin
               // No such master: sink every beat and flag it.
               sel_ready = 1'b1;
               drop      = sel_valid;
               hs        = sel_valid;
            end
            for (int unsigned i = 0; i < 3; i++) begin
               if (gnt_slv_q == 2'(i)) rready_s[i] = sel_ready;
            end
            if (hs && sel_last) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_slv_q <= '0;
         gnt_mst_q <= '0;
`ifdef RDATA_ROUTER_RR_EN
         rr_ptr_q  <= 2'd2;
`endif
      end else begin
         state_q   <= state_d;
         gnt_slv_q <= gnt_slv_d;
         gnt_mst_q <= gnt_mst_d;
`ifdef RDATA_ROUTER_RR_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

   assign RREADY_S0 = rready_s[0];
   assign RREADY_S1 = rready_s[1];
   assign RREADY_S2 = rready_s[2];

   assign RID_M0 = rid_m[0];  assign RDATA_M0 = rdata_m[0];  assign RRESP_M0 = rresp_m[0];
   assign RLAST_M0 = rlast_m[0];  assign RVALID_M0 = rvalid_m[0];
   assign RID_M1 = rid_m[1];  assign RDATA_M1 = rdata_m[1];  assign RRESP_M1 = rresp_m[1];
   assign RLAST_M1 = rlast_m[1];  assign RVALID_M1 = rvalid_m[1];
   assign RID_M2 = rid_m[2];  assign RDATA_M2 = rdata_m[2];  assign RRESP_M2 = rresp_m[2];
   assign RLAST_M2 = rlast_m[2];  assign RVALID_M2 = rvalid_m[2];

   assign BUSY = (state_q == LOCK);
   assign DROP = drop;

endmodule

// File: doc/rdata_router.md
RDATA_ROUTER -- requirements
Module: rdata_router

Interface
REQ-001 The block SHALL use these widths: `AXI_IDS_BITS (8), slave-side ID, master index in bits [7:4]; `AXI_ID_BITS (4), master-side ID; `AXI_DATA_BITS (32), read data.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have, for each slave i=0..2: RID_Si, input, 8 bits; RDATA_Si, input, 32 bits; RRESP_Si, input, 2 bits; RLAST_Si, input, 1 bit; RVALID_Si, input, 1 bit; RREADY_Si, output, 1 bit.
REQ-005 The block SHALL have, for each master j=0..2: RID_Mj, output, 4 bits; RDATA_Mj, output, 32 bits; RRESP_Mj, output, 2 bits; RLAST_Mj, output, 1 bit; RVALID_Mj, output, 1 bit; RREADY_Mj, input, 1 bit.
REQ-006 The block SHALL have port BUSY, output, 1 bit: high while a burst is locked.
REQ-007 The block SHALL have port DROP, output, 1 bit: one-cycle pulse per beat sunk to an invalid master index.

Function
REQ-008 The block SHALL be a two-state FSM, IDLE and LOCK, plus registers gnt_slv[1:0] and gnt_mst[3:0].
REQ-009 In IDLE, when any RVALID_Si=1, the block SHALL pick one slave per the arbitration rule (REQ-019), latch gnt_slv=i and gnt_mst=RID_Si[7:4], and enter LOCK at the next edge.
- Arbitration latency: one cycle.
- In IDLE, all RREADY_Si=0 and all RVALID_Mj=0.
REQ-010 In LOCK with gnt_mst in 0..2, the block SHALL drive master gnt_mst combinationally from the granted slave:
- RVALID_M = RVALID_S
- RDATA, RRESP, RLAST passed through
- RID_M = RID_S[3:0]
- RREADY_S = RREADY_M
REQ-011 In LOCK, all non-granted slaves SHALL see RREADY=0, and all non-target masters SHALL see RVALID=0 and zeroed data/ID/resp/last.
REQ-012 In LOCK with gnt_mst>2, the block SHALL hold RREADY_S=1 for the granted slave, present no master output, and pulse DROP=1 on every beat where RVALID_S=1.
REQ-013 A beat handshake with RLAST=1 SHALL return the FSM to IDLE at that edge.
- A new grant therefore starts no earlier than the following cycle (no back-to-back grant in the same cycle).
REQ-014 The block SHALL NOT re-decode RID mid-burst; gnt_mst is fixed for the whole burst.
REQ-015 The block SHALL NOT insert stalls while RVALID and RREADY are both held high inside a burst (one beat per cycle).
REQ-016 The block SHALL drive BUSY=1 exactly when state=LOCK.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL set state=IDLE, gnt_slv=0, gnt_mst=0, and the round-robin pointer=S2 (so S0 has highest priority first); all RVALID_Mj, RREADY_Si, BUSY and DROP SHALL be 0 and all master data/ID fields zero.
REQ-018 Assertion of rst mid-burst SHALL abandon the burst immediately; remaining beats are arbitrated afresh as new traffic after reset.

Configuration
REQ-019 With macro RDATA_ROUTER_RR_EN defined, the block SHALL arbitrate round-robin.
- Priority starts after the last granted slave.
- The pointer updates when a grant is taken.
- Without the macro, priority SHALL be fixed at S0>S1>S2 and no pointer register exists.

Verification
REQ-020 Single burst: S1 sends RID=8'h12, LEN=4 (4 beats), M1 RREADY=1 -> BUSY=1 one cycle later; M1 receives RID=4'h2 and 4 beats on consecutive cycles; IDLE after the RLAST beat.
REQ-021 Backpressure: M0 toggles RREADY 1,0,1,0 during a 2-beat burst from S0 -> RREADY_S0 mirrors RREADY_M0; data is held; no beat is lost or duplicated.
REQ-022 Simultaneous requests: S0, S1 and S2 all valid at IDLE -> fixed mode grants S0, S1, S2 in order; RR mode after a prior S0 grant grants S1, S2, S0.
REQ-023 Invalid index: S2 sends RID=8'h52 for 3 beats -> RREADY_S2=1, three DROP pulses, all RVALID_Mj=0.
REQ-024 Reset mid-burst: rst=1 after beat 2 of 4 -> next cycle BUSY=0 and all RVALID_Mj=0; after rst=0, the still-valid slave is re-granted.
